pipe_hazard_ctrl: RTL and testbench

- Control block that drives the flush/freeze inputs of the pipeline registers in the 5-stage ARM core: PC, IF/ID register, and the ID/EX register's flush.
- Detects RAW data hazards between the ID-stage sources and the EXE/MEM destinations, and squashes the wrong-path instructions on a taken branch.
- Runs a memory-wait FSM that freezes the whole pipe while the SRAM handshake is outstanding, with a timeout.
- Keeps saturating stall/flush statistics counters.

---
 rtl/arm_pipe_pkg.sv | 25 ++
 rtl/hazard_mem_fsm.sv | 60 ++++++
 rtl/pipe_hazard_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline hazard control slice:
// register-number width, memory-wait FSM states and operand compare helper.
package arm_pipe_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_t;

  // True when either used ID source names the given destination register.
  // The compare is exact over all REG_W bits, so R15 is treated like any other register.
  function automatic logic dep_hit(
    input logic             use_src1,
    input logic [REG_W-1:0] src1,
    input logic             use_src2,
    input logic [REG_W-1:0] src2,
    input logic [REG_W-1:0] dest
  );
    return (use_src1 && (src1 == dest)) || (use_src2 && (src2 == dest));
  endfunction

endpackage

// File: rtl/hazard_mem_fsm.sv
// Memory-wait FSM: tracks an outstanding SRAM access, raises mem_stall while
// the handshake is pending and flags a sticky error when it times out.
module hazard_mem_fsm
  import arm_pipe_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ready,
  output logic mem_stall,
  output logic mem_err
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] LAST_CNT = WCW'(TIMEOUT - 1);

  mem_state_t     state_reg;
  logic [WCW-1:0] wait_cnt_reg;
  logic           mem_err_reg;

  // State, wait counter and sticky error flag; an access aborted by reset is not replayed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A ready in the request cycle is a zero-wait access.
          if (mem_req && !mem_ready) begin
            state_reg    <= WAIT;
            wait_cnt_reg <= '0;
          end
        end
        WAIT: begin
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          if (mem_ready) begin
            state_reg <= IDLE;
          end else if (wait_cnt_reg == LAST_CNT) begin
            state_reg   <= ERR;
            mem_err_reg <= 1'b1;
          end
        end
        ERR: begin
          // Any late ready is dropped; the error stays latched.
          mem_err_reg <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_stall = rst && mem_req && !mem_ready && (state_reg != ERR);
  assign mem_err   = mem_err_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW hazard detection, branch squash, memory
// freeze priority mux and saturating stall/flush statistics.
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic             exe_b,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_all,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic             mem_stall;
  logic             exe_hit;
  logic             mem_hit;
  logic             hz;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  hazard_mem_fsm #(
    .TIMEOUT(TIMEOUT)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_ready(mem_ready),
    .mem_stall(mem_stall),
    .mem_err  (mem_err)
  );

  // With forwarding only a load in EXE can't be bypassed; without it any pending write is a hazard.
  always_comb begin
    exe_hit = dep_hit(id_use_src1, id_src1, id_use_src2, id_src2, exe_dest);
    mem_hit = dep_hit(id_use_src1, id_src1, id_use_src2, id_src2, mem_dest);
    if (forward_en) begin
      hz = exe_wb_en && exe_mem_read && exe_hit;
    end else begin
      hz = (exe_wb_en && exe_hit) || (mem_wb_en && mem_hit);
    end
  end

  // Priority: memory freeze, then taken branch, then data hazard; everything low in reset.
  always_comb begin
    freeze_pc   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    freeze_all  = 1'b0;
    if (!rst) begin
      freeze_pc = 1'b0;
    end else if (mem_stall) begin
      freeze_all = 1'b1;
      freeze_pc  = 1'b1;
    end else if (exe_b) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hz) begin
      freeze_pc   = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  // Saturating statistics: cycles frozen and branch flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (freeze_pc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (flush_if_id && (flush_cnt_reg != {CNT_W{1'b1}})) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (TIMEOUT=8, CNT_W=16).
module tb_pipe_hazard_ctrl;
  import arm_pipe_pkg::*;

  logic        clk;
  logic        rst;
  logic        forward_en;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_use_src1;
  logic        id_use_src2;
  logic [3:0]  exe_dest;
  logic        exe_wb_en;
  logic        exe_mem_read;
  logic        exe_b;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  logic        mem_req;
  logic        mem_ready;
  logic        freeze_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        freeze_all;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  pipe_hazard_ctrl #(
    .TIMEOUT(8),
    .CNT_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .forward_en  (forward_en),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_use_src1 (id_use_src1),
    .id_use_src2 (id_use_src2),
    .exe_dest    (exe_dest),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_read(exe_mem_read),
    .exe_b       (exe_b),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .freeze_pc   (freeze_pc),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .freeze_all  (freeze_all),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control outputs as one 4-bit vector {freeze_all, freeze_pc, flush_if_id, flush_id_ex}.
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, freeze_all, freeze_pc, flush_if_id, flush_id_ex}, {28'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    forward_en   = 1'b0;
    id_src1      = 4'd0;
    id_src2      = 4'd0;
    id_use_src1  = 1'b0;
    id_use_src2  = 1'b0;
    exe_dest     = 4'd0;
    exe_wb_en    = 1'b0;
    exe_mem_read = 1'b0;
    exe_b        = 1'b0;
    mem_dest     = 4'd0;
    mem_wb_en    = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    // Reset: hazard and memory request present, outputs must still be 0.
    id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; mem_req = 1'b1;
    #12;
    check_ctl("reset_ctl", 4'b0000);
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    check("reset_mem_err", 32'(mem_err), 32'd0);
    idle_inputs();
    rst = 1'b1;
    tick();

    // No-forward EXE RAW hazard on src1.
    id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1 check_ctl("raw_exe_nofwd", 4'b0101);
    tick();
    check("raw_exe_stall_cnt", 32'(stall_cnt), 32'd1);
    idle_inputs();
    #1 check_ctl("idle_after_raw", 4'b0000);

    // MEM-stage RAW on src2: hazard without forwarding, none with it.
    id_src2 = 4'd7; id_use_src2 = 1'b1; mem_dest = 4'd7; mem_wb_en = 1'b1;
    #1 check_ctl("raw_mem_nofwd", 4'b0101);
    forward_en = 1'b1;
    #1 check_ctl("raw_mem_fwd", 4'b0000);
    idle_inputs();

    // R15 compared exactly.
    id_src1 = 4'd15; id_use_src1 = 1'b1; exe_dest = 4'd14; exe_wb_en = 1'b1;
    #1 check_ctl("r15_vs_r14", 4'b0000);
    exe_dest = 4'd15;
    #1 check_ctl("r15_vs_r15", 4'b0101);
    id_use_src1 = 1'b0;
    #1 check_ctl("r15_unused", 4'b0000);
    idle_inputs();

    // Forwarding on: non-load is fine, load-use stalls for exactly that cycle.
    forward_en = 1'b1; id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1 check_ctl("fwd_alu", 4'b0000);
    exe_mem_read = 1'b1;
    #1 check_ctl("fwd_load_use", 4'b0101);
    tick();
    check("load_use_stall_cnt", 32'(stall_cnt), 32'd2);
    exe_mem_read = 1'b0;
    #1 check_ctl("load_use_gone", 4'b0000);
    tick();
    check("no_stall_cnt", 32'(stall_cnt), 32'd2);
    idle_inputs();

    // Branch beats hazard.
    id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_b = 1'b1;
    #1 check_ctl("branch_over_hz", 4'b0011);
    tick();
    check("branch_flush_cnt", 32'(flush_cnt), 32'd1);
    check("branch_stall_cnt", 32'(stall_cnt), 32'd2);
    idle_inputs();

    // Memory wait, ready on the 4th cycle.
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_ctl($sformatf("mem_wait_c%0d", i), 4'b1100);
      tick();
    end
    mem_ready = 1'b1;
    #1 check_ctl("mem_ready_cycle", 4'b0000);
    tick();
    check("mem_state_idle", 32'(dut.u_fsm.state_reg), 32'(IDLE));
    check("mem_err_clean", 32'(mem_err), 32'd0);
    check("mem_wait_stall_cnt", 32'(stall_cnt), 32'd5);
    mem_req = 1'b0; mem_ready = 1'b0;

    // Same wait with a taken branch held: no flush until the freeze drops.
    mem_req = 1'b1; exe_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_ctl($sformatf("mem_branch_c%0d", i), 4'b1100);
      tick();
    end
    mem_ready = 1'b1;
    #1 check_ctl("branch_after_ready", 4'b0011);
    tick();
    check("deferred_flush_cnt", 32'(flush_cnt), 32'd2);
    check("deferred_stall_cnt", 32'(stall_cnt), 32'd8);
    idle_inputs();

    // Timeout: 1 IDLE cycle plus 8 WAIT cycles, then ERR.
    mem_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1 check_ctl($sformatf("timeout_c%0d", i), 4'b1100);
      tick();
    end
    check("err_state", 32'(dut.u_fsm.state_reg), 32'(ERR));
    mem_ready = 1'b1;
    #1 check_ctl("err_no_stall", 4'b0000);
    tick();
    check("err_to_idle", 32'(dut.u_fsm.state_reg), 32'(IDLE));
    check("mem_err_set", 32'(mem_err), 32'd1);
    check("timeout_stall_cnt", 32'(stall_cnt), 32'd17);
    mem_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("mem_err_sticky", 32'(mem_err), 32'd1);

    // Asynchronous reset in the middle of a WAIT.
    mem_req = 1'b1;
    tick();
    check("pre_reset_wait", 32'(dut.u_fsm.state_reg), 32'(WAIT));
    #2 rst = 1'b0;
    #1 check_ctl("async_rst_ctl", 4'b0000);
    check("async_rst_state", 32'(dut.u_fsm.state_reg), 32'(IDLE));
    check("async_rst_mem_err", 32'(mem_err), 32'd0);
    check("async_rst_stall", 32'(stall_cnt), 32'd0);
    check("async_rst_flush", 32'(flush_cnt), 32'd0);
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();

    // Saturation of stall_cnt under a held hazard.
    id_src1 = 4'd3; id_use_src1 = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    check("stall_saturated", 32'(stall_cnt), 32'h0000_FFFF);
    check_ctl("sat_still_frozen", 4'b0101);
    tick();
    check("stall_no_wrap", 32'(stall_cnt), 32'h0000_FFFF);
    check("sat_flush_cnt", 32'(flush_cnt), 32'd0);
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
